// File: rtl/aduna_pkg.sv
// Purpose: shared widths and types for the aduna 4-bit registered adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aduna_pkg;

   localparam int ADUNA_W = 4;

   // One operand.
   typedef logic [ADUNA_W-1:0] aduna_op_t;

   // Exact add result: {carry, sum}.
   typedef logic [ADUNA_W:0]   aduna_res_t;

endpackage : aduna_pkg

// File: rtl/aduna_cla4.sv
// Purpose: 4-bit carry-lookahead adder core. It is purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: x, y  - operands
//        cin   - carry-in
//        s     - sum bits
//        cout  - carry-out
//        G, P  - group generate/propagate, for cascading into a wider lookahead
module aduna_cla4
   import aduna_pkg::*;
(
   input  logic [ADUNA_W-1:0] x,
   input  logic [ADUNA_W-1:0] y,
   input  logic               cin,
   output logic [ADUNA_W-1:0] s,
   output logic               cout,
   output logic               G,
   output logic               P
);

   logic [ADUNA_W-1:0] gen;
   logic [ADUNA_W-1:0] prop;
   logic [ADUNA_W:0]   c;

   assign gen  = x & y;
   assign prop = x ^ y;

   // Every carry is a flat two-level sum-of-products of gen, prop and cin.
   // No carry term depends on an earlier carry, so there is no ripple path.
   assign c[0] = cin;
   assign c[1] = gen[0]
               | (prop[0] & cin);
   assign c[2] = gen[1]
               | (prop[1] & gen[0])
               | (prop[1] & prop[0] & cin);
   assign c[3] = gen[2]
               | (prop[2] & gen[1])
               | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & cin);
   assign c[4] = gen[3]
               | (prop[3] & gen[2])
               | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0])
               | (prop[3] & prop[2] & prop[1] & prop[0] & cin);

   assign s    = prop ^ c[ADUNA_W-1:0];
   assign cout = c[4];

   // Group terms exclude cin, so a higher-level lookahead unit can combine them.
   assign G = gen[3]
            | (prop[3] & gen[2])
            | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
   assign P = &prop;

endmodule : aduna_cla4

// File: rtl/aduna.sv
// Purpose: 4-bit unsigned adder with a registered {c4, s} output and carry-in fixed at 0.
// Latency: 1 cycle. A new operand pair can be applied every cycle.
// Backpressure: none. The output register loads on every edge.
// Ports: clk - rising-edge clock
//        rst - synchronous active-high reset, which clears s and c4
//        x, y - unsigned operands
//        s  - registered sum, (x+y) mod 16
//        c4 - registered carry-out
module aduna
   import aduna_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [ADUNA_W-1:0] x,
   input  logic [ADUNA_W-1:0] y,
   output logic [ADUNA_W-1:0] s,
   output logic               c4
);

   aduna_op_t  sum_d;
   logic       cout_d;
   aduna_res_t res_q;
   // The group G/P outputs are reserved for future cascading and are not used here.
   logic [1:0] unused_grp;

   aduna_cla4 u_cla4 (
      .x    (x),
      .y    (y),
      .cin  (1'b0),
      .s    (sum_d),
      .cout (cout_d),
      .G    (unused_grp[1]),
      .P    (unused_grp[0])
   );

   // Reset has priority over the add and drops the result that was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
      end else begin
         res_q <= {cout_d, sum_d};
      end
   end

   assign c4 = res_q[ADUNA_W];
   assign s  = res_q[ADUNA_W-1:0];

endmodule : aduna

// File: tb/tb_aduna.sv
module tb_aduna;
   import aduna_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] s;
   logic       c4;

   aduna dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .y   (y),
      .s   (s),
      .c4  (c4)
   );

   always #5 clk = ~clk;

   aduna_res_t exp_q[$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {c4,s}=%h expected %h", tag, got, exp);
      end
   endtask

   // The inputs change on the falling edge. The expected result is queued when the inputs
   // are driven. The result is compared 1 ns after the following rising edge.
   task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input string tag);
      aduna_res_t e;
      @(negedge clk);
      rst = r;
      x   = a;
      y   = b;
      exp_q.push_back(r ? 5'd0 : ({1'b0, a} + {1'b0, b}));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_q_empty"}, 5'h1F, 5'h00);
      end else begin
         e = exp_q.pop_front();
         check(tag, {c4, s}, e);
      end
   endtask

   initial begin
      rst = 1'b1;
      x   = 4'hF;
      y   = 4'hF;

      // Reset is held with the operands at their maximum. Then reset is released.
      drive(1'b1, 4'hF, 4'hF, "rst_hold0");
      drive(1'b1, 4'hF, 4'hF, "rst_hold1");
      drive(1'b0, 4'hF, 4'hF, "rst_release_ff");

      // Basic add and carry cases.
      drive(1'b0, 4'b1001, 4'b0000, "basic_9_0");
      drive(1'b0, 4'hF, 4'h1, "carry_f_1");
      drive(1'b0, 4'h5, 4'hA, "nocarry_5_a");

      // Back-to-back operand pairs.
      drive(1'b0, 4'd3, 4'd4, "b2b_3_4");
      drive(1'b0, 4'd8, 4'd8, "b2b_8_8");
      drive(1'b0, 4'd7, 4'd9, "b2b_7_9");

      // Reset is asserted while an add is in flight. Then reset is released.
      drive(1'b1, 4'd6, 4'd7, "rst_mid");
      drive(1'b0, 4'd6, 4'd7, "post_rst_6_7");

      // All 256 operand pairs.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            drive(1'b0, 4'(i), 4'(j), $sformatf("exh_%0d_%0d", i, j));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_aduna
